// File: rtl/dmem_pkg.sv
// Shared types and constants for the data-memory responder.
package dmem_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam int WORD_BYTES = 4;
    localparam int ADDR_LSB   = 2;
    localparam int CNT_W      = 4;

    function automatic logic word_misaligned(input logic [31:0] a);
        return (a % 32'(WORD_BYTES)) != 32'd0;
    endfunction

endpackage

// File: rtl/dmem_array.sv
// Single-port word RAM: synchronous write, synchronous read, no reset.
// The read register only updates on a read strobe, so it holds the last load.
module dmem_array #(
    parameter int DEPTH_LOG2 = 10
) (
    input  logic                  clk,
    input  logic                  i_we,
    input  logic                  i_re,
    input  logic [DEPTH_LOG2-1:0] i_addr,
    input  logic [31:0]           i_wdata,
    output logic [31:0]           o_rdata
);

    logic [31:0] r_mem [0:(1<<DEPTH_LOG2)-1];
    logic [31:0] r_rdata;

    // Storage write and registered read port.
    always_ff @(posedge clk) begin
        if (i_we) begin
            r_mem[i_addr] <= i_wdata;
        end
        if (i_re) begin
            r_rdata <= r_mem[i_addr];
        end
    end

    assign o_rdata = r_rdata;

endmodule

// File: rtl/dmem_responder.sv
// Multi-cycle data-memory responder for the MIPS M stage with a pipeline stall.
// Optional performance counters are enabled by defining DMEM_PERF_CNT_EN.
module dmem_responder
    import dmem_pkg::*;
#(
    parameter int DEPTH_LOG2 = 10,
    parameter int LATENCY    = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        memread,
    input  logic        memwrite,
    input  logic [31:0] addr,
    input  logic [31:0] writedata,
    output logic [31:0] readdata,
    output logic        stall,
    output logic        misalign
`ifdef DMEM_PERF_CNT_EN
    ,
    output logic [31:0] load_count,
    output logic [31:0] store_count,
    output logic [31:0] stall_cycles
`endif
);

    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(LATENCY - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    state_t                r_state;
    state_t                w_state_nxt;
    logic [CNT_W-1:0]      r_cnt;
    logic [CNT_W-1:0]      w_cnt_nxt;
    logic                  w_fsm_stall;
    logic                  w_req;
    logic                  w_accept;
    logic                  w_to_done;
    logic                  w_cur_store;
    logic                  w_cur_mis;
    logic                  w_re;
    logic                  w_we;
    logic [DEPTH_LOG2-1:0] w_addr_idx;
    logic [DEPTH_LOG2-1:0] w_ram_idx;
    logic [DEPTH_LOG2-1:0] r_idx;
    logic                  r_is_store;
    logic                  r_mis;
    logic                  r_misalign;
    logic                  r_rd_zero;
    logic [31:0]           w_rdata;
    logic                  w_unused;

    assign w_req      = memread | memwrite;
    assign w_accept   = (r_state == IDLE) && w_req;
    assign w_addr_idx = addr[DEPTH_LOG2+ADDR_LSB-1:ADDR_LSB];
    assign w_unused   = ^addr[31:DEPTH_LOG2+ADDR_LSB];

    // With LATENCY==1 the DONE transition happens straight out of IDLE, so
    // the live request is used until the latched copy becomes valid.
    assign w_cur_store = w_accept ? memwrite : r_is_store;
    assign w_cur_mis   = w_accept ? word_misaligned(addr) : r_mis;
    assign w_ram_idx   = (r_state == IDLE) ? w_addr_idx : r_idx;
    assign w_to_done   = (r_state != DONE) && (w_state_nxt == DONE);
    assign w_re        = w_to_done && !w_cur_store && !w_cur_mis;
    assign w_we        = (r_state == DONE) && r_is_store && !r_mis;

    // State and latency counter register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= IDLE;
            r_cnt   <= {CNT_W{1'b0}};
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    // Next-state, counter and stall decode.
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_fsm_stall = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_req) begin
                    w_fsm_stall = 1'b1;
                    w_cnt_nxt   = CNT_LOAD;
                    w_state_nxt = (LATENCY == 1) ? DONE : WAIT;
                end else begin
                    w_state_nxt = IDLE;
                end
            end
            WAIT: begin
                w_fsm_stall = 1'b1;
                w_cnt_nxt   = r_cnt - CNT_ONE;
                if (r_cnt <= CNT_ONE) begin
                    w_state_nxt = DONE;
                end else begin
                    w_state_nxt = WAIT;
                end
            end
            DONE: begin
                w_state_nxt = IDLE;
                w_cnt_nxt   = {CNT_W{1'b0}};
            end
            default: begin
                w_state_nxt = IDLE;
                w_cnt_nxt   = {CNT_W{1'b0}};
            end
        endcase
    end

    assign stall = w_fsm_stall & reset;

    // Access type, index and alignment captured at acceptance.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_is_store <= 1'b0;
            r_mis      <= 1'b0;
            r_idx      <= {DEPTH_LOG2{1'b0}};
        end else if (w_accept) begin
            r_is_store <= memwrite;
            r_mis      <= word_misaligned(addr);
            r_idx      <= w_addr_idx;
        end
    end

    // Misalign pulse and readdata-zero flag, both updated on entry to DONE.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_misalign <= 1'b0;
            r_rd_zero  <= 1'b1;
        end else begin
            r_misalign <= w_to_done && w_cur_mis;
            if (w_to_done && !w_cur_store) begin
                r_rd_zero <= w_cur_mis;
            end
        end
    end

    dmem_array #(
        .DEPTH_LOG2(DEPTH_LOG2)
    ) u_array (
        .clk    (clk),
        .i_we   (w_we),
        .i_re   (w_re),
        .i_addr (w_ram_idx),
        .i_wdata(writedata),
        .o_rdata(w_rdata)
    );

    // The RAM read register has no reset, so reset and misaligned loads mask it.
    assign readdata = r_rd_zero ? 32'h0000_0000 : w_rdata;
    assign misalign = r_misalign;

`ifdef DMEM_PERF_CNT_EN
    logic [31:0] r_load_count;
    logic [31:0] r_store_count;
    logic [31:0] r_stall_cycles;

    // Completed-access and stall-cycle counters.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_load_count   <= 32'd0;
            r_store_count  <= 32'd0;
            r_stall_cycles <= 32'd0;
        end else begin
            if ((r_state == DONE) && !r_mis) begin
                if (r_is_store) begin
                    r_store_count <= r_store_count + 32'd1;
                end else begin
                    r_load_count <= r_load_count + 32'd1;
                end
            end
            if (stall) begin
                r_stall_cycles <= r_stall_cycles + 32'd1;
            end
        end
    end

    assign load_count   = r_load_count;
    assign store_count  = r_store_count;
    assign stall_cycles = r_stall_cycles;
`endif

endmodule

// File: tb/tb_dmem_responder.sv
// Directed, table-driven bench for dmem_responder (DEPTH_LOG2=10, LATENCY=2).
module tb_dmem_responder;

    localparam int LAT = 2;
    localparam int NV  = 17;

    typedef struct {
        logic        rd;
        logic        wr;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic        chk_rd;
        logic [31:0] exp_rd;
        logic        exp_mis;
    } vec_t;

    logic        clk = 1'b0;
    logic        reset;
    logic        memread;
    logic        memwrite;
    logic [31:0] addr;
    logic [31:0] writedata;
    logic [31:0] readdata;
    logic        stall;
    logic        misalign;
`ifdef DMEM_PERF_CNT_EN
    logic [31:0] load_count;
    logic [31:0] store_count;
    logic [31:0] stall_cycles;
`endif

    int checks   = 0;
    int failures = 0;
    vec_t vecs [NV];
    vec_t post_v;

    always #5 clk = ~clk;

    dmem_responder #(.DEPTH_LOG2(10), .LATENCY(LAT)) dut (
        .clk      (clk),
        .reset    (reset),
        .memread  (memread),
        .memwrite (memwrite),
        .addr     (addr),
        .writedata(writedata),
        .readdata (readdata),
        .stall    (stall),
        .misalign (misalign)
`ifdef DMEM_PERF_CNT_EN
        ,
        .load_count  (load_count),
        .store_count (store_count),
        .stall_cycles(stall_cycles)
`endif
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    // Drive one access, count stall cycles, check DONE-cycle outputs, then release.
    task automatic do_access(input vec_t v, input string tag);
        int  n;
        bit  done;
        @(negedge clk);
        memread   = v.rd;
        memwrite  = v.wr;
        addr      = v.addr;
        writedata = v.wdata;
        n    = 0;
        done = 1'b0;
        for (int c = 0; c < 20 && !done; c++) begin
            #1;
            if (stall) begin
                n++;
                @(negedge clk);
            end else begin
                done = 1'b1;
            end
        end
        if (!done) begin
            checks++;
            failures++;
            $display("FAIL %s_timeout actual=stall_stuck required=done", tag);
        end else begin
            check({tag, "_stall_cnt"}, 32'(n), 32'(LAT));
            check({tag, "_misalign"}, {31'd0, misalign}, {31'd0, v.exp_mis});
            if (v.chk_rd) begin
                check({tag, "_readdata"}, readdata, v.exp_rd);
            end
        end
        @(negedge clk);
        memread  = 1'b0;
        memwrite = 1'b0;
        #1;
        check({tag, "_misalign_after"}, {31'd0, misalign}, 32'd0);
        check({tag, "_stall_after"}, {31'd0, stall}, 32'd0);
    endtask

    initial begin
        vecs[0]  = '{1'b0, 1'b1, 32'h0000_0010, 32'hDEAD_BEEF, 1'b1, 32'h0000_0000, 1'b0};
        vecs[1]  = '{1'b1, 1'b0, 32'h0000_0010, 32'h0000_0000, 1'b1, 32'hDEAD_BEEF, 1'b0};
        vecs[2]  = '{1'b0, 1'b1, 32'h0000_1004, 32'h1234_5678, 1'b1, 32'hDEAD_BEEF, 1'b0};
        vecs[3]  = '{1'b1, 1'b0, 32'h0000_0004, 32'h0000_0000, 1'b1, 32'h1234_5678, 1'b0};
        vecs[4]  = '{1'b0, 1'b1, 32'h0000_0020, 32'h0000_0000, 1'b1, 32'h1234_5678, 1'b0};
        vecs[5]  = '{1'b0, 1'b1, 32'h0000_0022, 32'hFFFF_FFFF, 1'b0, 32'h0000_0000, 1'b1};
        vecs[6]  = '{1'b1, 1'b0, 32'h0000_0020, 32'h0000_0000, 1'b1, 32'h0000_0000, 1'b0};
        vecs[7]  = '{1'b1, 1'b0, 32'h0000_0010, 32'h0000_0000, 1'b1, 32'hDEAD_BEEF, 1'b0};
        vecs[8]  = '{1'b1, 1'b0, 32'h0000_0013, 32'h0000_0000, 1'b1, 32'h0000_0000, 1'b1};
        vecs[9]  = '{1'b1, 1'b0, 32'h0000_0004, 32'h0000_0000, 1'b1, 32'h1234_5678, 1'b0};
        vecs[10] = '{1'b1, 1'b1, 32'h0000_0040, 32'hA5A5_A5A5, 1'b1, 32'h1234_5678, 1'b0};
        vecs[11] = '{1'b1, 1'b0, 32'h0000_0040, 32'h0000_0000, 1'b1, 32'hA5A5_A5A5, 1'b0};
        vecs[12] = '{1'b1, 1'b0, 32'h0000_1010, 32'h0000_0000, 1'b1, 32'hDEAD_BEEF, 1'b0};
        vecs[13] = '{1'b0, 1'b1, 32'h0000_0FFC, 32'h0BAD_F00D, 1'b1, 32'hDEAD_BEEF, 1'b0};
        vecs[14] = '{1'b1, 1'b0, 32'h0000_0FFC, 32'h0000_0000, 1'b1, 32'h0BAD_F00D, 1'b0};
        vecs[15] = '{1'b0, 1'b1, 32'h0000_0080, 32'h2222_2222, 1'b1, 32'h0BAD_F00D, 1'b0};
        vecs[16] = '{1'b1, 1'b0, 32'h0000_0080, 32'h0000_0000, 1'b1, 32'h2222_2222, 1'b0};
        post_v   = '{1'b1, 1'b0, 32'h0000_0080, 32'h0000_0000, 1'b1, 32'h2222_2222, 1'b0};

        // Reset with a load request held: stall must stay low while in reset.
        reset     = 1'b0;
        memread   = 1'b1;
        memwrite  = 1'b0;
        addr      = 32'h0000_0010;
        writedata = 32'h0000_0000;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("rst_stall", {31'd0, stall}, 32'd0);
            check("rst_readdata", readdata, 32'd0);
            check("rst_misalign", {31'd0, misalign}, 32'd0);
        end
        memread = 1'b0;
        reset   = 1'b1;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            check("post_rst_stall", {31'd0, stall}, 32'd0);
        end
`ifdef DMEM_PERF_CNT_EN
        check("perf_load_rst", load_count, 32'd0);
        check("perf_store_rst", store_count, 32'd0);
        check("perf_stall_rst", stall_cycles, 32'd0);
`endif

        for (int k = 0; k < NV; k++) begin
            do_access(vecs[k], $sformatf("v%0d", k));
        end

        // Reset while a store of 0x11111111 to 0x80 sits in WAIT.
        @(negedge clk);
        memwrite  = 1'b1;
        addr      = 32'h0000_0080;
        writedata = 32'h1111_1111;
        @(negedge clk);
        check("midrst_pre_stall", {31'd0, stall}, 32'd1);
        reset = 1'b0;
        #1;
        check("midrst_stall", {31'd0, stall}, 32'd0);
        check("midrst_readdata", readdata, 32'd0);
        memwrite = 1'b0;
        repeat (3) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        check("midrst_release_stall", {31'd0, stall}, 32'd0);
        check("midrst_release_misalign", {31'd0, misalign}, 32'd0);
`ifdef DMEM_PERF_CNT_EN
        check("perf_load_midrst", load_count, 32'd0);
        check("perf_store_midrst", store_count, 32'd0);
        check("perf_stall_midrst", stall_cycles, 32'd0);
`endif
        do_access(post_v, "post_midrst");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/dmem_responder.md
Name: dmem_responder

Overview:
- Data-memory responder for the pipelined MIPS core. It serves the Memory-stage load/store requests (address, store data, read/write strobes) and returns load data to the Writeback path.
- Models a multi-cycle word-addressed SRAM. It asserts `stall` so the hazard unit freezes the pipeline until the access completes.

Parameters:
- DEPTH_LOG2, 10, log2 of number of 32-bit words (1024 words = 4 KiB).
- LATENCY, 2, stall cycles per access; legal range 1..15.

Ports:
- clk  input  1  system clock; all state changes on rising edge.
- reset  input  1  asynchronous, active-low reset.
- memread  input  1  load request from M stage.
- memwrite  input  1  store request from M stage.
- addr  input  32  byte address (aluoutM).
- writedata  input  32  store data (writedataM).
- readdata  output  32  load result, registered.
- stall  output  1  freeze request to hazard unit; combinational from state and request.
- misalign  output  1  one-cycle pulse: access with addr[1:0]!=0.

Behaviour:
- Reset state:
  - reset low: FSM=IDLE, counter=0, readdata=0, misalign=0.
  - stall=0 while reset is asserted. Array contents are not cleared.
  - Reset mid-access: FSM returns to IDLE immediately. A pending store is dropped and readdata is cleared.
- Index: idx = addr[DEPTH_LOG2+1:2]. Upper address bits are ignored, so addresses wrap modulo 2^(DEPTH_LOG2+2).
- Request definition: req = memread | memwrite. If both are high, treat it as a store; the load is ignored.
- FSM states IDLE, WAIT, DONE; 4-bit down counter cnt.
  - IDLE:
    - req=0: stay in IDLE, stall=0.
    - req=1: stall=1 and cnt loads LATENCY-1.
    - Next state is DONE if LATENCY==1, else WAIT.
  - WAIT:
    - stall=1; cnt decrements each cycle.
    - When cnt==1 at the edge, next state is DONE.
  - DONE:
    - stall=0, so the pipeline advances at the end of this cycle; next state is IDLE unconditionally.
    - The request is still held, but it is not re-accepted in DONE.
- Stall count and total time: stall is high for exactly LATENCY consecutive cycles per access, so one access occupies LATENCY+1 cycles.
- Requester rule: addr, writedata, memread and memwrite are held stable from acceptance through DONE. The bench checks this; the RTL does not.
- Load: on the edge entering DONE, readdata <= array[idx]. readdata holds that value until the next completed load or reset. Stores do not change readdata.
- Store: array[idx] <= writedata on the edge leaving DONE.
- Read-after-write to the same idx:
  - Back-to-back accesses are separated by at least one IDLE cycle, so a following load observes the new data.
  - No bypass is required.
- Misalignment:
  - Condition: req accepted with addr[1:0]!=0.
  - Effects: misalign pulses high during the DONE cycle; the store is suppressed; readdata is loaded with 0.
  - Timing is unchanged.
- A req falling mid-access (protocol violation) is ignored: the access completes with the latched type.
  - The FSM latches is_store and idx at acceptance.

Optional Feature:
- Macro: DMEM_PERF_CNT_EN.
- Defined: adds outputs load_count[31:0], store_count[31:0] and stall_cycles[31:0].
  - load_count and store_count increment once per completed access (in DONE), excluding misaligned accesses.
  - stall_cycles increments on every cycle with stall=1.
  - All three reset to 0 and wrap at 2^32.
- Undefined: these ports and registers do not exist; timing is identical.

Decomposition:
- Package dmem_pkg:
  - state enum {IDLE, WAIT, DONE}
  - WORD_BYTES=4, ADDR_LSB=2
  - CNT_W=4
- Sub-module dmem_array: single-port RAM, synchronous write, synchronous read; no reset; parameter DEPTH_LOG2.
- FSM, counter and perf counters stay in dmem_responder.

Test Plan:
- Reset while idle → readdata=0, stall=0, misalign=0. Hold reset low 3 cycles, release; no spurious stall.
- Store 0xDEADBEEF to addr 0x0000_0010, then load 0x10 with LATENCY=2 → store stall 2 cycles; load stall 2 cycles; readdata=0xDEADBEEF in the load's DONE cycle.
- Wrap: store 0x12345678 to 0x0000_1004, load 0x0000_0004 (DEPTH_LOG2=10) → readdata=0x12345678.
- Misaligned store 0xFFFFFFFF to 0x0000_0022 → misalign=1 for one cycle. A subsequent load of 0x20 returns the prior value 0x00000000 (after initialising 0x20 to 0).
- Simultaneous memread=memwrite=1 with writedata=0xA5A5A5A5 at 0x40 → treated as store; readdata unchanged; later load 0x40 returns 0xA5A5A5A5.
- Reset asserted in WAIT of a store of 0x11111111 to 0x80 → stall=0 immediately; a later load of 0x80 returns the old value. With DMEM_PERF_CNT_EN, all counters read 0.
